// File: rtl/kt_chk_pkg.sv
// Shared types and constants for the 5x5 knight's-tour checker.
package kt_chk_pkg;
    localparam int BOARD_N  = 5;
    localparam int CELL_NUM = 25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_WAIT,
        S_CHECK,
        S_REPORT
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_OOB     = 3'd1;
    localparam logic [2:0] ERR_REVISIT = 3'd2;
    localparam logic [2:0] ERR_JUMP    = 3'd3;
    localparam logic [2:0] ERR_INDEX   = 3'd4;
    localparam logic [2:0] ERR_PREFIX  = 3'd5;
    localparam logic [2:0] ERR_SHORT   = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT = 3'd7;

    // Row-major cell number; only meaningful for in-bound coordinates.
    function automatic logic [4:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
        return 5'({2'b00, x} * 5'd5 + {2'b00, y});
    endfunction
endpackage

// File: rtl/kt_move_legal.sv
// Combinational knight-move test between two board cells.
module kt_move_legal (
    input  logic [2:0] prev_x,
    input  logic [2:0] prev_y,
    input  logic [2:0] cur_x,
    input  logic [2:0] cur_y,
    output logic       is_knight_move
);
    logic signed [3:0] dx, dy;
    logic [3:0] adx, ady;

    always_comb begin
        dx  = $signed({1'b0, cur_x}) - $signed({1'b0, prev_x});
        dy  = $signed({1'b0, cur_y}) - $signed({1'b0, prev_y});
        adx = dx[3] ? 4'(-dx) : 4'(dx);
        ady = dy[3] ? 4'(-dy) : 4'(dy);
        is_knight_move = ((adx == 4'd1) && (ady == 4'd2)) || ((adx == 4'd2) && (ady == 4'd1));
    end
endmodule

// File: rtl/kt_tour_checker.sv
// Judges a 25-beat knight's-tour result against the snooped prefix.
// Optional wait-for-result timeout is enabled by defining KT_CHK_TIMEOUT_EN.
module kt_tour_checker
    import kt_chk_pkg::*;
#(
    parameter int TIMEOUT_CYC = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_x,
    input  logic [2:0] in_y,
    input  logic [4:0] move_num,
    input  logic       kt_out_valid,
    input  logic [2:0] kt_out_x,
    input  logic [2:0] kt_out_y,
    input  logic [4:0] kt_move_out,
    output logic       chk_done,
    output logic       chk_pass,
    output logic [2:0] err_code,
    output logic [4:0] err_step
);
    state_t state, state_nxt;

    logic [5:0]          prefix [CELL_NUM];
    logic [4:0]          pcnt, mnum, bcnt;
    logic [CELL_NUM-1:0] visited;
    logic [2:0]          prev_x, prev_y;
    logic [2:0]          err_cur;
    logic [4:0]          step_cur;

    logic       start, pstore, beat, last, tmo, go_report;
    logic       oob, legal;
    logic [4:0] cidx, fin_step;
    logic [2:0] beat_code, fin_code;

    kt_move_legal u_legal (
        .prev_x         (prev_x),
        .prev_y         (prev_y),
        .cur_x          (kt_out_x),
        .cur_y          (kt_out_y),
        .is_knight_move (legal)
    );

    // Per-beat error, highest priority first.
    always_comb begin
        cidx      = cell_idx(kt_out_x, kt_out_y);
        oob       = (kt_out_x > 3'(BOARD_N - 1)) || (kt_out_y > 3'(BOARD_N - 1));
        beat_code = ERR_NONE;
        if (oob)
            beat_code = ERR_OOB;
        else if ((bcnt <= mnum) && ({kt_out_x, kt_out_y} != prefix[bcnt - 5'd1]))
            beat_code = ERR_PREFIX;
        else if (kt_move_out != bcnt)
            beat_code = ERR_INDEX;
        else if (visited[cidx])
            beat_code = ERR_REVISIT;
        else if ((bcnt != 5'd1) && !legal)
            beat_code = ERR_JUMP;
    end

`ifdef KT_CHK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state != S_WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + CNT_W'(1);
    end
    assign tmo = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // fin_* is the running first error including the beat/gap/timeout of this cycle.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        pstore    = 1'b0;
        beat      = 1'b0;
        fin_code  = err_cur;
        fin_step  = step_cur;
        last      = (bcnt == 5'(CELL_NUM));
        unique case (state)
            S_IDLE: if (in_valid) begin
                start     = 1'b1;
                state_nxt = S_PREFIX;
            end
            S_REPORT: begin
                start     = in_valid;
                state_nxt = in_valid ? S_PREFIX : S_IDLE;
            end
            S_PREFIX: begin
                if (in_valid)
                    pstore = 1'b1;
                else if (kt_out_valid) begin
                    beat      = 1'b1;
                    state_nxt = S_CHECK;
                end else
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (kt_out_valid) begin
                    beat      = 1'b1;
                    state_nxt = S_CHECK;
                end else if (tmo) begin
                    state_nxt = S_REPORT;
                    fin_code  = ERR_TIMEOUT;
                    fin_step  = 5'd0;
                end
            end
            S_CHECK: begin
                if (kt_out_valid) begin
                    beat = 1'b1;
                    if (last) state_nxt = S_REPORT;
                end else begin
                    state_nxt = S_REPORT;
                    if (err_cur == ERR_NONE) begin
                        fin_code = ERR_SHORT;
                        fin_step = bcnt;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (beat && (err_cur == ERR_NONE) && (beat_code != ERR_NONE)) begin
            fin_code = beat_code;
            fin_step = bcnt;
        end
    end

    assign go_report = (state_nxt == S_REPORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_done <= 1'b0;
            chk_pass <= 1'b0;
            err_code <= ERR_NONE;
            err_step <= '0;
            visited  <= '0;
            err_cur  <= ERR_NONE;
            step_cur <= '0;
            pcnt     <= '0;
            mnum     <= '0;
            bcnt     <= 5'd1;
            prev_x   <= '0;
            prev_y   <= '0;
        end else begin
            chk_done <= go_report;
            if (go_report) begin
                chk_pass <= (fin_code == ERR_NONE);
                err_code <= fin_code;
                err_step <= fin_step;
            end
            if (start) begin
                visited  <= '0;
                err_cur  <= ERR_NONE;
                step_cur <= '0;
                pcnt     <= 5'd1;
                mnum     <= move_num;
                bcnt     <= 5'd1;
            end else begin
                if (pstore && (pcnt < 5'(CELL_NUM)))
                    pcnt <= pcnt + 5'd1;
                if (beat) begin
                    bcnt     <= bcnt + 5'd1;
                    prev_x   <= kt_out_x;
                    prev_y   <= kt_out_y;
                    err_cur  <= fin_code;
                    step_cur <= fin_step;
                    if (!oob) visited[cidx] <= 1'b1;
                end
            end
        end
    end

    // Prefix storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (start)
            prefix[0] <= {in_x, in_y};
        else if (pstore && (pcnt < 5'(CELL_NUM)))
            prefix[pcnt] <= {in_x, in_y};
    end
endmodule

// File: tb/tb_kt_tour_checker.sv
// Bench for kt_tour_checker: directed table, randomized corruptions vs. a rule-level model, reset/timeout sequences.
module tb_kt_tour_checker;
    localparam int TO = 20;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, kt_out_valid = 1'b0;
    logic [2:0] in_x = '0, in_y = '0, kt_out_x = '0, kt_out_y = '0;
    logic [4:0] move_num = '0, kt_move_out = '0;
    logic       chk_done, chk_pass;
    logic [2:0] err_code;
    logic [4:0] err_step;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kt_tour_checker #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .move_num(move_num), .kt_out_valid(kt_out_valid), .kt_out_x(kt_out_x),
        .kt_out_y(kt_out_y), .kt_move_out(kt_move_out), .chk_done(chk_done),
        .chk_pass(chk_pass), .err_code(err_code), .err_step(err_step)
    );

    // A legal 5x5 tour starting at (0,0).
    int tour_x[25] = '{0,1,0,2,4,3,4,2,0,1,3,4,2,0,1,3,4,3,1,0,2,4,3,1,2};
    int tour_y[25] = '{0,2,4,3,4,2,0,1,2,4,3,1,0,1,3,4,2,0,1,3,4,3,1,0,2};

    int px[25], py[25], bx[25], by[25], bi[25];
    int mnum, nsend, nbeats, dly;

    typedef struct {
        int mnum; int cstep; int cx; int cy; int istep; int ival; int nbeats; int code; int step;
    } vec_t;
    vec_t vt[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic load_tour();
        for (int k = 0; k < 25; k++) begin
            bx[k] = tour_x[k]; by[k] = tour_y[k]; bi[k] = k + 1;
            px[k] = tour_x[k]; py[k] = tour_y[k];
        end
    endtask

    // Rule-level reference: first error over the pattern, 0/0 if none.
    task automatic model(output int code, output int step);
        bit vis[5][5];
        int c, x, y, dx, dy;
        code = 0; step = 0;
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) vis[i][j] = 0;
        for (int n = 1; n <= 25; n++) begin
            if (n > nbeats) begin
                if (code == 0) begin code = 6; step = n; end
                break;
            end
            x = bx[n-1]; y = by[n-1]; c = 0;
            if (x > 4 || y > 4) c = 1;
            else if (n <= mnum && (x != px[n-1] || y != py[n-1])) c = 5;
            else if (bi[n-1] != n) c = 4;
            else if (vis[x][y]) c = 2;
            else if (n > 1) begin
                dx = x - bx[n-2]; dy = y - by[n-2];
                if (dx*dx + dy*dy != 5) c = 3;
            end
            if (code == 0 && c != 0) begin code = c; step = n; end
            if (x <= 4 && y <= 4) vis[x][y] = 1;
        end
    endtask

    task automatic run_pattern(input string tag, input int exp_code, input int exp_step);
        int extra;
        extra = $urandom_range(0, 2);
        @(negedge clk);
        for (int k = 0; k < nsend; k++) begin
            if (k > 0) @(negedge clk);
            in_valid = 1'b1; in_x = 3'(px[k]); in_y = 3'(py[k]);
            move_num = (k == 0) ? 5'(mnum) : 5'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (dly) @(negedge clk);
        for (int n = 0; n < nbeats; n++) begin
            if (n > 0) @(negedge clk);
            kt_out_valid = 1'b1; kt_out_x = 3'(bx[n]); kt_out_y = 3'(by[n]); kt_move_out = 5'(bi[n]);
            in_valid = (n >= 2 && n < nbeats - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (nbeats < 25) begin
            @(negedge clk);
            kt_out_valid = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, " done"}, int'(chk_done), 1);
        check({tag, " code"}, int'(err_code), exp_code);
        check({tag, " step"}, int'(err_step), exp_step);
        check({tag, " pass"}, int'(chk_pass), int'(exp_code == 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            kt_out_valid = (i < extra);
            kt_out_x = 3'($urandom); kt_out_y = 3'($urandom); kt_move_out = 5'($urandom);
            @(posedge clk); #1;
            check({tag, " pulse"}, int'(chk_done), 0);
        end
        check({tag, " hold"}, int'(err_code), exp_code);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rst done"}, int'(chk_done), 0);
        check({tag, " rst pass"}, int'(chk_pass), 0);
        check({tag, " rst code"}, int'(err_code), 0);
        check({tag, " rst step"}, int'(err_step), 0);
    endtask

    task automatic no_done_for(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (chk_done) seen++;
        end
        check({tag, " no verdict"}, seen, 0);
        check_zero({tag, " after"});
    endtask

    initial begin
        int ec, es, ncor;
        vt[0]  = '{1,  0, 0, 0, 0, 0, 25, 0, 0};
        vt[1]  = '{1,  7, 0, 4, 0, 0, 25, 2, 7};
        vt[2]  = '{1, 10, 2, 5, 0, 0, 25, 1, 10};
        vt[3]  = '{1, 11, 3, 4, 0, 0, 25, 3, 11};
        vt[4]  = '{3,  2, 2, 1, 0, 0, 25, 5, 2};
        vt[5]  = '{1,  0, 0, 0, 0, 0, 12, 6, 13};
        vt[6]  = '{1,  0, 0, 0, 5, 6, 25, 4, 5};
        vt[7]  = '{25, 0, 0, 0, 0, 0, 25, 0, 0};
        vt[8]  = '{1, 25, 5, 2, 0, 0, 25, 1, 25};
        vt[9]  = '{1,  1, 0, 1, 0, 0, 25, 5, 1};
        vt[10] = '{4,  0, 0, 0, 0, 0, 24, 6, 25};
        vt[11] = '{1,  4, 0, 0, 0, 0, 25, 2, 4};

        #1;
        check_zero("power-up");
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 12; v++) begin
            load_tour();
            mnum = vt[v].mnum; nsend = mnum; nbeats = vt[v].nbeats; dly = v % 3;
            if (vt[v].cstep != 0) begin bx[vt[v].cstep-1] = vt[v].cx; by[vt[v].cstep-1] = vt[v].cy; end
            if (vt[v].istep != 0) bi[vt[v].istep-1] = vt[v].ival;
            run_pattern($sformatf("vec%0d", v), vt[v].code, vt[v].step);
        end

        for (int r = 0; r < 40; r++) begin
            load_tour();
            mnum  = $urandom_range(1, 25);
            nsend = mnum + $urandom_range(0, 2);
            if (nsend > 25) nsend = 25;
            for (int k = mnum; k < nsend; k++) begin px[k] = $urandom_range(0, 7); py[k] = $urandom_range(0, 7); end
            if ($urandom_range(0, 3) == 0) begin
                int k = $urandom_range(0, mnum - 1);
                px[k] = $urandom_range(0, 4); py[k] = $urandom_range(0, 4);
            end
            ncor = $urandom_range(0, 2);
            for (int c = 0; c < ncor; c++) begin
                int s = $urandom_range(0, 24);
                bx[s] = $urandom_range(0, 5); by[s] = $urandom_range(0, 5);
            end
            if ($urandom_range(0, 4) == 0) bi[$urandom_range(0, 24)] = $urandom_range(0, 31);
            nbeats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : 25;
            dly = $urandom_range(0, 3);
            model(ec, es);
            run_pattern($sformatf("rand%0d", r), ec, es);
        end

        // Reset while results are streaming aborts without a verdict.
        load_tour();
        mnum = 1; nsend = 1; nbeats = 25; dly = 1;
        bx[6] = 0; by[6] = 4;
        run_pattern("pre-abort", 2, 7);
        @(negedge clk);
        in_valid = 1'b1; in_x = 3'd0; in_y = 3'd0; move_num = 5'd1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            kt_out_valid = 1'b1; kt_out_x = 3'(tour_x[n]); kt_out_y = 3'(tour_y[n]); kt_move_out = 5'(n + 1);
        end
        @(negedge clk);
        rst_n = 1'b0; kt_out_valid = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        no_done_for("abort", 30);

`ifdef KT_CHK_TIMEOUT_EN
        begin
            int cyc;
            @(negedge clk);
            in_valid = 1'b1; in_x = 3'd0; in_y = 3'd0; move_num = 5'd2;
            @(negedge clk);
            in_x = 3'd1; in_y = 3'd2;
            @(negedge clk);
            in_valid = 1'b0;
            cyc = 0;
            while (cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
                if (chk_done) break;
            end
            check("timeout latency", cyc, TO + 1);
            check("timeout code", int'(err_code), 7);
            check("timeout step", int'(err_step), 0);
            check("timeout pass", int'(chk_pass), 0);

            @(negedge clk);
            in_valid = 1'b1; in_x = 3'd0; in_y = 3'd0; move_num = 5'd1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (10) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_zero("timeout-abort");
            @(negedge clk);
            rst_n = 1'b1;
            no_done_for("timeout-abort", 40);
        end
`endif

        load_tour();
        mnum = 1; nsend = 1; nbeats = 25; dly = 0;
        run_pattern("recover", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
